// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor with a start/busy/done handshake.
// Operands are captured at start, then DIGIT bits per clock ripple through a
// small slice whose carry is registered between digits. The partial sum is
// shifted in from the top, so after N = WIDTH/DIGIT steps it is fully aligned.
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] s,
   output logic             c,
   output logic             ov,
   output logic             busy,
   output logic             done
);

   localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   // Reject parameter sets that cannot be split into whole digits.
   generate
      if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $fatal(1, "serial_addsub: WIDTH must be >= 2 and DIGIT must divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic             capture;
   logic             step;
   logic             finish;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;      // effective B (already inverted for subtract)
   logic             carry_reg;  // carry chained between digits
   logic             sub_reg;
   logic [WIDTH-1:0] acc_reg;    // partial sum, filled from the top
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] s_reg;
   logic             c_reg;
   logic             ov_reg;

   logic [DIGIT:0]   cy;
   logic [DIGIT-1:0] slice_sum;
   logic [WIDTH-1:0] acc_next;
   logic             last_digit;

   // DIGIT-wide ripple slice working on the lowest unprocessed bits.
   assign cy[0] = carry_reg;
   generate
      for (genvar gi = 0; gi < DIGIT; gi++) begin : g_slice
         assign slice_sum[gi] = a_reg[gi] ^ b_reg[gi] ^ cy[gi];
         assign cy[gi+1]      = (a_reg[gi] & b_reg[gi]) | (cy[gi] & (a_reg[gi] ^ b_reg[gi]));
      end
   endgenerate

   // New digit enters at the top; after N steps the LSB digit lands at bit 0.
   assign acc_next   = (acc_reg >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
   assign last_digit = (cnt_reg == CW'(N - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and datapath control strobes.
   always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               capture    = 1'b1;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (last_digit) begin
               finish     = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            // Accepting here gives back-to-back operations without a bubble.
            if (start) begin
               capture    = 1'b1;
               state_next = ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Operand capture, digit stepping and result load on completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         sub_reg   <= 1'b0;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         s_reg     <= '0;
         c_reg     <= 1'b0;
         ov_reg    <= 1'b0;
      end else if (capture) begin
         a_reg     <= a;
         b_reg     <= b ^ {WIDTH{sub}};
         carry_reg <= ci ^ sub;
         sub_reg   <= sub;
         cnt_reg   <= '0;
      end else if (step) begin
         a_reg     <= a_reg >> DIGIT;
         b_reg     <= b_reg >> DIGIT;
         carry_reg <= cy[DIGIT];
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_reg + 1'b1;
         if (finish) begin
            // On the last digit the slice's top bit is the operand MSB, so its
            // carry-in/carry-out give the whole-word overflow.
            s_reg  <= acc_next;
            c_reg  <= cy[DIGIT] ^ sub_reg;
            ov_reg <= cy[DIGIT] ^ cy[DIGIT-1];
         end
      end
   end

   assign s    = s_reg;
   assign c    = c_reg;
   assign ov   = ov_reg;
   assign busy = (state_reg == ST_RUN);
   assign done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: four configurations (8/1, 8/4, 8/8, 4/2) checked
// every cycle against an arithmetic reference with a countdown latency model,
// plus literal expectations for the directed vectors.
module tb_serial_addsub;

   logic clk = 1'b0;
   logic rst;
   logic sub;
   logic ci;
   logic [7:0] a;
   logic [7:0] b;
   logic start_v [4];

   logic [7:0] s81, s84, s88;
   logic [3:0] s42;
   logic c_w [4];
   logic ov_w [4];
   logic busy_w [4];
   logic done_w [4];

   logic [7:0] s_o [4];
   logic c_o [4];
   logic ov_o [4];
   logic busy_o [4];
   logic done_o [4];

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   int NLAT [4] = '{8, 2, 1, 2};
   int WID  [4] = '{8, 8, 8, 4};

   // reference model state: {ov, c, s}
   logic [9:0] res_m [4] = '{default: '0};
   logic [9:0] pend_m [4] = '{default: '0};
   logic busy_m [4] = '{default: 1'b0};
   logic done_m [4] = '{default: 1'b0};
   int rem_m [4] = '{default: 0};

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d81 (
      .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .a(a), .b(b), .ci(ci),
      .s(s81), .c(c_w[0]), .ov(ov_w[0]), .busy(busy_w[0]), .done(done_w[0]));
   serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d84 (
      .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .a(a), .b(b), .ci(ci),
      .s(s84), .c(c_w[1]), .ov(ov_w[1]), .busy(busy_w[1]), .done(done_w[1]));
   serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d88 (
      .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .a(a), .b(b), .ci(ci),
      .s(s88), .c(c_w[2]), .ov(ov_w[2]), .busy(busy_w[2]), .done(done_w[2]));
   serial_addsub #(.WIDTH(4), .DIGIT(2)) u_d42 (
      .clk(clk), .rst(rst), .start(start_v[3]), .sub(sub), .a(a[3:0]), .b(b[3:0]), .ci(ci),
      .s(s42), .c(c_w[3]), .ov(ov_w[3]), .busy(busy_w[3]), .done(done_w[3]));

   always_comb begin
      s_o[0] = s81;
      s_o[1] = s84;
      s_o[2] = s88;
      s_o[3] = {4'b0000, s42};
      for (int k = 0; k < 4; k++) begin
         c_o[k]    = c_w[k];
         ov_o[k]   = ov_w[k];
         busy_o[k] = busy_w[k];
         done_o[k] = done_w[k];
      end
   end

   // Reference arithmetic: unsigned sum/difference for s and c, true signed
   // result range test for ov. Returns {ov, c, s}.
   function automatic logic [9:0] calc(input int w, input int aa, input int bb,
                                       input logic ss, input logic cc);
      int mask, r, sa, sb, sr, smax, smin;
      logic cbit, obit;
      logic [7:0] sbits;
      mask = (1 << w) - 1;
      aa   = aa & mask;
      bb   = bb & mask;
      smax = (1 << (w - 1)) - 1;
      smin = -(1 << (w - 1));
      sa   = (aa > smax) ? aa - (1 << w) : aa;
      sb   = (bb > smax) ? bb - (1 << w) : bb;
      if (!ss) begin
         r    = aa + bb + int'(cc);
         cbit = (r > mask);
         sr   = sa + sb + int'(cc);
      end else begin
         r    = aa - bb - int'(cc);
         cbit = (r < 0);
         sr   = sa - sb - int'(cc);
      end
      obit  = (sr > smax) || (sr < smin);
      sbits = 8'(r & mask);
      return {obit, cbit, sbits};
   endfunction

   task automatic chk(input string nm, input int k, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s dut=%0d actual=%0h required=%0h t=%0t", nm, k, act, exp, $time);
      end
   endtask

   // Cycle-level expectation: accept when not busy, complete N edges later.
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (rst) begin
            busy_m[k] <= 1'b0;
            done_m[k] <= 1'b0;
            res_m[k]  <= '0;
            rem_m[k]  <= 0;
         end else if (!busy_m[k] && start_v[k]) begin
            busy_m[k] <= 1'b1;
            done_m[k] <= 1'b0;
            rem_m[k]  <= NLAT[k] - 1;
            pend_m[k] <= calc(WID[k], int'(a), int'(b), sub, ci);
         end else if (busy_m[k]) begin
            if (rem_m[k] == 0) begin
               busy_m[k] <= 1'b0;
               done_m[k] <= 1'b1;
               res_m[k]  <= pend_m[k];
            end else begin
               rem_m[k] <= rem_m[k] - 1;
            end
         end else begin
            done_m[k] <= 1'b0;
         end
      end
   end

   // Compare every DUT against the model away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 4; k++) begin
            chk("cyc_s",    k, int'(s_o[k]),    int'(res_m[k][7:0]));
            chk("cyc_c",    k, int'(c_o[k]),    int'(res_m[k][8]));
            chk("cyc_ov",   k, int'(ov_o[k]),   int'(res_m[k][9]));
            chk("cyc_busy", k, int'(busy_o[k]), int'(busy_m[k]));
            chk("cyc_done", k, int'(done_o[k]), int'(done_m[k]));
         end
      end
   end

   task automatic lit(input string nm, input int k, input logic [7:0] es,
                      input logic ec, input logic eo);
      chk({nm, "_s"},  k, int'(s_o[k]),  int'(es));
      chk({nm, "_c"},  k, int'(c_o[k]),  int'(ec));
      chk({nm, "_ov"}, k, int'(ov_o[k]), int'(eo));
   endtask

   // Launch one operation on DUT k and wait (bounded) for its done pulse.
   // poke > 0 re-asserts start with other operands that many edges in.
   task automatic op(input int k, input logic [7:0] aa, input logic [7:0] bb,
                     input logic ss, input logic cc, input int poke);
      int n;
      a = aa; b = bb; sub = ss; ci = cc;
      start_v[k] = 1'b1;
      @(posedge clk); #1;
      start_v[k] = 1'b0;
      n = 0;
      while (!done_o[k] && n < 40) begin
         if (poke != 0 && n == poke) begin
            start_v[k] = 1'b1;
            a = ~aa; b = 8'h33; sub = ~ss;
         end else begin
            start_v[k] = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      start_v[k] = 1'b0;
      chk("latency", k, n, NLAT[k]);
   endtask

   logic [7:0] va [6] = '{8'hFF, 8'h10, 8'h7F, 8'h05, 8'h80, 8'h03};
   logic [7:0] vb [6] = '{8'h01, 8'h20, 8'h01, 8'h07, 8'h01, 8'h04};
   logic       vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic       vc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [7:0] es [6] = '{8'h00, 8'h31, 8'h80, 8'hFE, 8'h7F, 8'h07};
   logic       ec [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic       eo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      rst = 1'b1; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
      for (int k = 0; k < 4; k++) start_v[k] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // model pins against hand-computed values
      chk("pin_add", 0, int'(calc(8, 'h7F, 'h01, 1'b0, 1'b0)), int'({1'b1, 1'b0, 8'h80}));
      chk("pin_sub", 0, int'(calc(8, 'h05, 'h07, 1'b1, 1'b0)), int'({1'b0, 1'b1, 8'hFE}));
      chk("pin_w4",  3, int'(calc(4, 'h8, 'h1, 1'b1, 1'b0)),   int'({1'b1, 1'b0, 8'h07}));

      // reset state
      for (int k = 0; k < 4; k++) begin
         lit("reset", k, 8'h00, 1'b0, 1'b0);
         chk("reset_busy", k, int'(busy_o[k]), 0);
         chk("reset_done", k, int'(done_o[k]), 0);
      end

      // directed vectors on all three 8-bit configurations
      for (int k = 0; k < 3; k++) begin
         for (int v = 0; v < 6; v++) begin
            op(k, va[v], vb[v], vs[v], vc[v], 0);
            lit("vec", k, es[v], ec[v], eo[v]);
            if (v % 2 == 0) begin
               repeat (2) @(posedge clk);
               #1;
            end
         end
      end

      // start during RUN is ignored; first result stands
      repeat (2) @(posedge clk);
      #1;
      op(0, 8'h10, 8'h20, 1'b0, 1'b1, 3);
      lit("ignored", 0, 8'h31, 1'b0, 1'b0);
      // start during the done cycle: back-to-back, latency still 8
      op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
      lit("b2b", 0, 8'h00, 1'b1, 1'b0);

      // reset in the middle of an operation
      repeat (2) @(posedge clk);
      #1;
      a = 8'h7F; b = 8'h01; sub = 1'b0; ci = 1'b0;
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      lit("midrst", 0, 8'h00, 1'b0, 1'b0);
      chk("midrst_busy", 0, int'(busy_o[0]), 0);
      chk("midrst_done", 0, int'(done_o[0]), 0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("no_done_after_rst", 0, int'(done_o[0]), 0);
      end
      op(0, 8'h03, 8'h04, 1'b0, 1'b0, 0);
      lit("after_rst", 0, 8'h07, 1'b0, 1'b0);

      // WIDTH=4, DIGIT=2: every sub/ci/a/b combination
      for (int ss = 0; ss < 2; ss++) begin
         for (int cc = 0; cc < 2; cc++) begin
            for (int aa = 0; aa < 16; aa++) begin
               for (int bb = 0; bb < 16; bb++) begin
                  op(3, 8'(aa), 8'(bb), 1'(ss), 1'(cc), 0);
               end
            end
         end
      end
      // spot literal on the 4-bit unit: 8 - 1 signed overflows
      op(3, 8'h08, 8'h01, 1'b1, 1'b0, 0);
      lit("w4_sub", 3, 8'h07, 1'b0, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Multi-cycle, parametrised adder/subtractor.
- Successor to the team's 1-bit combinational full-adder cell: processes two WIDTH-bit operands DIGIT bits per clock through an internal DIGIT-wide ripple slice.
- Provides carry/borrow-out and signed overflow.
- Uses a start/busy/done handshake so it can be shared by datapath controllers that can tolerate WIDTH/DIGIT cycles of latency in exchange for minimal adder area.

Parameters:
- WIDTH, 8: operand and result width in bits; must be at least 2.
- DIGIT, 1: bits processed per cycle. Must divide WIDTH exactly; checked at elaboration, fatal error otherwise.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a new operation; sampled only when busy=0.
- sub  input  1  0 = add, 1 = subtract; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- ci  input  1  carry-in for add, borrow-in for subtract; captured with start.
- s  output  WIDTH  result (registered); stable between completions.
- c  output  1  carry-out for add, borrow-out for subtract.
- ov  output  1  two's-complement signed overflow.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse marking that s/c/ov have just been updated.

Behaviour:
- Reset: while rst=1 at a clock edge, the block takes state IDLE and sets s=0, c=0, ov=0, busy=0, done=0, clears the digit counter and discards any operation in flight. start is ignored on any edge where rst=1.
- Arithmetic:
  - Effective B is b XOR {WIDTH{sub}}.
  - Effective carry-in is ci XOR sub (subtract computes a - b - ci).
  - Sum: s = (a + effB + effCin) mod 2^WIDTH.
  - c is the raw final carry XOR sub, i.e. the borrow-out in subtract mode.
  - ov = carry into MSB XOR carry out of MSB. Equivalently: add overflows when a and b have equal MSBs and s[MSB] differs from them; subtract overflows when a and b have different MSBs and s[MSB] differs from a[MSB].
- Let N = WIDTH/DIGIT.
- State IDLE (busy=0):
  - On an edge with start=1, capture a, effB, effCin and sub.
  - Clear the digit counter and go to RUN.
  - busy=1 from the next cycle.
- State RUN (busy=1):
  - Each edge processes the DIGIT least-significant unprocessed bits through the slice and shifts the partial sum in from the top.
  - The slice carry is registered and chained to the next digit.
  - The counter increments on each such edge.
  - On the N-th RUN edge, load s, c and ov from the final slice values; set done=1 and busy=0; go to DONE.
- State DONE: lasts exactly one cycle with done=1.
  - If start=1 on that edge, accept it exactly as in IDLE (back-to-back operation, no bubble). done falls and busy rises on the next cycle.
  - Otherwise go to IDLE with done=0.
- Timing: done is high in the cycle that begins N edges after the edge that sampled start. busy is high for exactly N cycles per operation.
- start while busy=1 is ignored. Operand and sub changes during RUN have no effect because captured copies are used.
- s, c and ov change only on the completing edge or on reset. They hold their values through IDLE and through the whole next operation until that operation's completing edge.
- DIGIT=WIDTH is legal: N=1, with done one cycle after start.
- Overflow and carry are computed on the full captured operation, never per digit.
- No combinational path from any input to any output.

Test Plan:
- WIDTH=8, DIGIT=1; start with a=8'hFF, b=8'h01, ci=0, sub=0 -> busy high 8 cycles; done pulses once, 8 cycles after start; s=8'h00, c=1, ov=0. Then a=8'h10, b=8'h20, ci=1 -> s=8'h31, c=0, ov=0.
- Signed edges, add a=8'h7F, b=8'h01 -> s=8'h80, c=0, ov=1. Subtract a=8'h05, b=8'h07, ci=0 -> s=8'hFE, c=1 (borrow), ov=0. Subtract a=8'h80, b=8'h01 -> s=8'h7F, c=0, ov=1.
- Handshake: pulse start again 3 cycles into an operation with different operands -> ignored; first result unaffected. Assert start during the done cycle -> second operation completes exactly 8 cycles later with no idle cycle; s holds the first result until then.
- Reset mid-operation: assert rst 4 cycles after start -> next cycle s=0, c=0, ov=0, busy=0, done=0. No done pulse follows. A subsequent start of 8'h03+8'h04 yields 8'h07 with normal latency.
- DIGIT=4 (N=2) and DIGIT=8 (N=1): same vectors as above -> identical s/c/ov, with done 2 and 1 cycles after start respectively.
- WIDTH=4, DIGIT=2: all 2*2*16*16 combinations of sub, ci, a and b -> s, c and ov match a reference model on every completion; exactly one done per start.
